stepper_full_step: RTL and testbench

STEPPER_FULL_STEP -- requirements
Module: stepper_full_step

---
 rtl/stepper_full_step_pkg.sv | 32 +++
 rtl/stepper_full_step_tick.sv | 29 ++
 rtl/stepper_full_step.sv | 129 ++++++++++++
 tb/tb_stepper_full_step.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_full_step_pkg.sv
// Shared constants for the full-step stepper driver: FSM encoding, pattern table, sync depth.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package stepper_full_step_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of synchronizer flops in front of the step_clk edge detector
  localparam int SYNC_DEPTH = 2;

  // Two-phase-on full-step coil patterns, {A, B, A_n, B_n}
  localparam logic [3:0] PAT_0 = 4'b1100;
  localparam logic [3:0] PAT_1 = 4'b0110;
  localparam logic [3:0] PAT_2 = 4'b0011;
  localparam logic [3:0] PAT_3 = 4'b1001;

  // Map a 2-bit phase index onto its coil pattern
  function automatic logic [3:0] full_step_pattern(input logic [1:0] phase);
    logic [3:0] pat;
    case (phase)
      2'd0:    pat = PAT_0;
      2'd1:    pat = PAT_1;
      2'd2:    pat = PAT_2;
      default: pat = PAT_3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/stepper_full_step_tick.sv
// Synchronizes the slow step_clk into core clk and emits a one-cycle tick per rising edge.
// Latency: tick is consumed on the 3rd clk edge after the step_clk rising edge.
// Backpressure: none; ticks are never stored, a consumer that ignores one loses it.
module step_tick_sync
  import stepper_full_step_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step_clk,
  output logic tick
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_edge;

  // Shift step_clk through the synchronizer and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], step_clk};
      r_edge <= r_sync[SYNC_DEPTH-1];
    end
  end

  assign tick = r_sync[SYNC_DEPTH-1] & ~r_edge;

endmodule

// File: rtl/stepper_full_step.sv
// Full-step (two-phase-on) stepper motor move controller with position tracking.
// Latency: coil/position update on the clk edge that consumes a tick; busy/done one cycle after start.
// Backpressure: start is ignored unless idle; ticks outside RUN are dropped.
module stepper_full_step
  import stepper_full_step_pkg::*;
#(
  parameter int STEP_W  = 16,
  parameter int HOLD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_clk,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  input  logic              abort,
  output logic [3:0]        coil,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] position
);

  localparam logic [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  logic              w_tick;

  logic [1:0]        r_state;
  logic [1:0]        r_phase;
  logic              r_dir;
  logic [STEP_W-1:0] r_rem;
  logic [STEP_W-1:0] r_pos;
  logic [3:0]        r_coil;
  logic              r_busy;
  logic              r_done;

  logic [1:0]        w_state_nxt;
  logic [1:0]        w_phase_nxt;
  logic              w_dir_nxt;
  logic [STEP_W-1:0] w_rem_nxt;
  logic [STEP_W-1:0] w_pos_nxt;
  logic [3:0]        w_coil_nxt;

  step_tick_sync u_tick (
    .clk      (clk),
    .rst      (rst),
    .step_clk (step_clk),
    .tick     (w_tick)
  );

  // Next-state logic: move launch, per-tick stepping, abort and completion
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    w_rem_nxt   = r_rem;
    w_pos_nxt   = r_pos;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (steps != '0) begin
            w_dir_nxt   = dir;
            w_rem_nxt   = steps;
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // abort beats a coincident tick: no step is taken
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_dir) begin
            w_phase_nxt = r_phase + 2'd1;
            w_pos_nxt   = r_pos + ONE;
          end else begin
            w_phase_nxt = r_phase - 2'd1;
            w_pos_nxt   = r_pos - ONE;
          end
          w_rem_nxt = r_rem - ONE;
          if (r_rem == ONE) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Coil drive follows the next phase; de-energized outside RUN when holding is disabled
  always_comb begin
    w_coil_nxt = 4'b0000;
    if ((w_state_nxt == ST_RUN) || (HOLD_EN != 0)) begin
      w_coil_nxt = full_step_pattern(w_phase_nxt);
    end
  end

  // State and registered outputs; reset overrides every input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
      r_dir   <= 1'b0;
      r_rem   <= '0;
      r_pos   <= '0;
      r_coil  <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_dir   <= w_dir_nxt;
      r_rem   <= w_rem_nxt;
      r_pos   <= w_pos_nxt;
      r_coil  <= w_coil_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign coil     = r_coil;
  assign busy     = r_busy;
  assign done     = r_done;
  assign position = r_pos;

endmodule

// File: tb/tb_stepper_full_step.sv
// Scoreboard bench for stepper_full_step: one holding and one non-holding instance share stimulus.
// Latency: checks step results on the negedge after the position changes.
// Backpressure: n/a.
module tb_stepper_full_step;

  logic        clk;
  logic        rst;
  logic        step_clk;
  logic        start;
  logic        dir;
  logic [15:0] steps;
  logic        abort;

  logic [3:0]  coil, coil0;
  logic        busy, busy0;
  logic        done, done0;
  logic [15:0] position, pos0;

  typedef struct packed {
    logic [3:0]  coil;
    logic [3:0]  coil0;
    logic [15:0] pos;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_errors;
  logic        mon_en;
  logic [15:0] prev_pos;
  int          done_cnt;
  int          done0_cnt;
  logic        busy_seen;

  logic        m_run;
  logic        m_dir;
  logic [1:0]  m_phase;
  logic [15:0] m_pos;
  logic [15:0] m_rem;

  stepper_full_step #(.STEP_W(16), .HOLD_EN(1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .step_clk (step_clk),
    .start    (start),
    .dir      (dir),
    .steps    (steps),
    .abort    (abort),
    .coil     (coil),
    .busy     (busy),
    .done     (done),
    .position (position)
  );

  stepper_full_step #(.STEP_W(16), .HOLD_EN(0)) u_dut_nohold (
    .clk      (clk),
    .rst      (rst),
    .step_clk (step_clk),
    .start    (start),
    .dir      (dir),
    .steps    (steps),
    .abort    (abort),
    .coil     (coil0),
    .busy     (busy0),
    .done     (done0),
    .position (pos0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pat(input logic [1:0] ph);
    logic [3:0] tbl [4];
    tbl[0] = 4'b1100;
    tbl[1] = 4'b0110;
    tbl[2] = 4'b0011;
    tbl[3] = 4'b1001;
    return tbl[ph];
  endfunction

  // Output monitor: count pulses and compare every observed step against the scoreboard
  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (done0) done0_cnt++;
    if (busy)  busy_seen = 1'b1;
    if (mon_en && (position !== prev_pos)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_step", {16'h0, position}, {16'h0, prev_pos});
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("step_coil", {28'h0, coil}, {28'h0, e.coil});
        check("step_coil_nohold", {28'h0, coil0}, {28'h0, e.coil0});
        check("step_pos", {16'h0, position}, {16'h0, e.pos});
        check("step_pos_nohold", {16'h0, pos0}, {16'h0, e.pos});
      end
    end
    prev_pos = position;
  end

  task automatic model_reset();
    m_run   = 1'b0;
    m_dir   = 1'b0;
    m_phase = 2'd0;
    m_pos   = 16'h0;
    m_rem   = 16'h0;
    sb_q.delete();
  endtask

  // All tasks begin and end 1 time unit after a rising clk edge
  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1 mon_en = 1'b1;
  endtask

  task automatic start_move(input logic d, input logic [15:0] n);
    start = 1'b1;
    dir   = d;
    steps = n;
    if (!m_run && n != 16'h0) begin
      m_run = 1'b1;
      m_dir = d;
      m_rem = n;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic step_pulse(input logic abort_on_tick);
    step_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = abort_on_tick;
    @(posedge clk);
    #1 abort = 1'b0;
    if (m_run) begin
      if (abort_on_tick) begin
        m_run = 1'b0;
      end else begin
        exp_t e;
        m_phase = m_dir ? m_phase + 2'd1 : m_phase - 2'd1;
        m_pos   = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
        m_rem   = m_rem - 16'd1;
        e.coil  = pat(m_phase);
        e.coil0 = (m_rem == 16'h0) ? 4'b0000 : pat(m_phase);
        e.pos   = m_pos;
        sb_q.push_back(e);
        if (m_rem == 16'h0) m_run = 1'b0;
      end
    end
    step_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mon_en    = 1'b0;
    prev_pos  = 16'h0;
    done_cnt  = 0;
    done0_cnt = 0;
    busy_seen = 1'b0;
    rst       = 1'b1;
    step_clk  = 1'b0;
    start     = 1'b0;
    dir       = 1'b0;
    steps     = 16'h0;
    abort     = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_coil", {28'h0, coil}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_pos", {16'h0, position}, 32'h0);
    check("rst_coil_nohold", {28'h0, coil0}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("hold_after_rst", {28'h0, coil}, 32'hC);
    check("nohold_idle", {28'h0, coil0}, 32'h0);
    mon_en = 1'b1;

    // Forward 4 steps
    done_cnt = 0;
    done0_cnt = 0;
    start_move(1'b1, 16'd4);
    check("busy_after_start", {31'h0, busy}, 32'h1);
    check("busy_nohold_match", {31'h0, busy0}, 32'h1);
    check("nohold_run_coil", {28'h0, coil0}, 32'hC);
    for (int i = 0; i < 4; i++) step_pulse(1'b0);
    check("fwd_pos", {16'h0, position}, 32'd4);
    check("fwd_done_cnt", done_cnt, 1);
    check("fwd_done0_cnt", done0_cnt, 1);
    check("fwd_busy", {31'h0, busy}, 32'h0);
    check("fwd_hold_coil", {28'h0, coil}, 32'hC);
    check("fwd_nohold_coil", {28'h0, coil0}, 32'h0);
    check("fwd_sb_empty", sb_q.size(), 0);

    // Reverse 2 steps from position 0 (wrap below zero)
    do_reset();
    done_cnt = 0;
    start_move(1'b0, 16'd2);
    for (int i = 0; i < 2; i++) step_pulse(1'b0);
    check("rev_pos", {16'h0, position}, 32'hFFFE);
    check("rev_coil", {28'h0, coil}, 32'h3);
    check("rev_done_cnt", done_cnt, 1);
    check("rev_sb_empty", sb_q.size(), 0);

    // Zero-length move
    busy_seen = 1'b0;
    done_cnt = 0;
    start_move(1'b1, 16'd0);
    check("zero_done", {31'h0, done}, 32'h1);
    check("zero_nohold_done_coil", {28'h0, coil0}, 32'h0);
    @(posedge clk);
    #1;
    check("zero_done_fall", {31'h0, done}, 32'h0);
    check("zero_busy_seen", {31'h0, busy_seen}, 32'h0);
    check("zero_coil", {28'h0, coil}, 32'h3);
    check("zero_pos", {16'h0, position}, 32'hFFFE);
    check("zero_done_cnt", done_cnt, 1);

    // Abort after 3rd tick, coincident with 4th; later ticks ignored
    do_reset();
    done_cnt = 0;
    start_move(1'b1, 16'd10);
    for (int i = 0; i < 3; i++) step_pulse(1'b0);
    step_pulse(1'b1);
    check("abort_busy", {31'h0, busy}, 32'h0);
    step_pulse(1'b0);
    step_pulse(1'b0);
    check("abort_pos", {16'h0, position}, 32'd3);
    check("abort_coil", {28'h0, coil}, 32'h9);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_sb_empty", sb_q.size(), 0);

    // Second start mid-move is ignored, then reset mid-move
    done_cnt = 0;
    start_move(1'b0, 16'd5);
    step_pulse(1'b0);
    start_move(1'b1, 16'd2);
    step_pulse(1'b0);
    check("mid_pos", {16'h0, position}, 32'd1);
    check("mid_busy", {31'h0, busy}, 32'h1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_coil", {28'h0, coil}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_pos", {16'h0, position}, 32'h0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_done_cnt", done_cnt, 0);
    check("midrst_sb_empty", sb_q.size(), 0);
    mon_en = 1'b1;

    // Non-holding instance across a 3-step move
    done0_cnt = 0;
    check("nohold_idle2", {28'h0, coil0}, 32'h0);
    start_move(1'b1, 16'd3);
    for (int i = 0; i < 3; i++) step_pulse(1'b0);
    check("nohold_end_coil", {28'h0, coil0}, 32'h0);
    check("nohold_end_pos", {16'h0, pos0}, 32'd3);
    check("nohold_done_cnt", done0_cnt, 1);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
